// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment display controllers.
package disp_pkg;

  // Non-numeric digit codes understood by the scan/decode block
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hB;
  localparam logic [3:0] CODE_C     = 4'hC;
  localparam logic [3:0] CODE_H     = 4'hD;
  localparam logic [3:0] CODE_L     = 4'hE;
  localparam logic [3:0] CODE_P     = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_DATA = 2'd1,
    SHOW_MSG  = 2'd2
  } disp_state_e;

  // Encoding of the src output
  localparam logic [1:0] SRC_IDLE = 2'd0;
  localparam logic [1:0] SRC_DATA = 2'd1;
  localparam logic [1:0] SRC_MSG  = 2'd2;

  // Replicate one digit code across all eight digit positions
  function automatic logic [31:0] fill_code(input logic [3:0] code);
    return {8{code}};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: free-running prescaler with a synchronous clear.
// tick is high during the cycle the prescaler sits at its terminal count.
module ms_tick_gen #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic sclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler counts 0..CLK_PER_MS-1 and wraps; clr restarts the millisecond
  always_ff @(posedge sclk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == TERM);

endmodule

// File: rtl/disp_source_arbiter.sv
// Display source arbiter: shares the 8-digit display between a live data channel
// and one-shot messages that pre-empt data, are held a minimum time and may blink.
module disp_source_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 50000,
  parameter int unsigned HOLD_MS    = 1000,
  parameter int unsigned BLINK_MS   = 250
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [31:0] data_digits,
  input  logic        msg_req,
  input  logic [31:0] msg_digits,
  input  logic        msg_blink,
  output logic        msg_ack,
  output logic        msg_done,
  output logic        msg_busy,
  output logic [1:0]  src,
  output logic [3:0]  bit_7,
  output logic [3:0]  bit_6,
  output logic [3:0]  bit_5,
  output logic [3:0]  bit_4,
  output logic [3:0]  bit_3,
  output logic [3:0]  bit_2,
  output logic [3:0]  bit_1,
  output logic [3:0]  bit_0
);

  localparam int unsigned MW = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
  localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [MW-1:0] HOLD_TERM  = MW'(HOLD_MS);
  localparam logic [MW-1:0] HOLD_LAST  = MW'(HOLD_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  disp_state_e r_state;
  disp_state_e w_state_next;

  logic [31:0]   r_msg_digits;
  logic          r_msg_blink;
  logic [MW-1:0] r_ms;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [31:0]   r_disp;
  logic [1:0]    r_src;
  logic          r_ack;
  logic          r_done;
  logic          r_busy;

  logic [31:0] w_disp_next;
  logic [1:0]  w_src_next;
  logic        w_tick;
  logic        w_expire;
  logic        w_take;

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_ms_tick_gen (
    .sclk(sclk),
    .rst (rst),
    .clr (w_take),
    .tick(w_tick)
  );

  // Hold time ends on the tick that brings the ms counter to HOLD_MS
  assign w_expire = (r_state == SHOW_MSG) && w_tick && (r_ms == HOLD_LAST);
  // A request is accepted whenever not busy, or back-to-back at expiry
  assign w_take   = msg_req && ((r_state != SHOW_MSG) || w_expire);

  // Next-state selection; messages take priority over data
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, SHOW_DATA: begin
        if (msg_req) begin
          w_state_next = SHOW_MSG;
        end else if (data_valid) begin
          w_state_next = SHOW_DATA;
        end else begin
          w_state_next = IDLE;
        end
      end
      SHOW_MSG: begin
        if (w_expire && !msg_req) begin
          w_state_next = data_valid ? SHOW_DATA : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Next display contents; the ack cycle keeps the previous picture on screen
  always_comb begin
    w_disp_next = r_disp;
    w_src_next  = r_src;
    if (r_state == SHOW_MSG) begin
      w_src_next  = SRC_MSG;
      w_disp_next = (r_msg_blink && r_phase) ? fill_code(CODE_BLANK) : r_msg_digits;
    end else if (!msg_req) begin
      if (data_valid) begin
        w_src_next  = SRC_DATA;
        w_disp_next = data_digits;
      end else begin
        w_src_next  = SRC_IDLE;
        w_disp_next = fill_code(CODE_DASH);
      end
    end
  end

  // State, message register, hold/blink timers and registered outputs
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_msg_digits <= fill_code(CODE_BLANK);
      r_msg_blink  <= 1'b0;
      r_ms         <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_disp       <= fill_code(CODE_BLANK);
      r_src        <= SRC_IDLE;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_disp  <= w_disp_next;
      r_src   <= w_src_next;
      r_ack   <= w_take;
      r_done  <= w_expire;
      r_busy  <= (r_state == SHOW_MSG);
      if (w_take) begin
        r_msg_digits <= msg_digits;
        r_msg_blink  <= msg_blink;
        r_ms         <= '0;
        r_blink_cnt  <= '0;
        r_phase      <= 1'b0;
      end else if ((r_state == SHOW_MSG) && w_tick) begin
        if (r_ms != HOLD_TERM) begin
          r_ms <= r_ms + MW'(1);
        end
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  assign msg_ack  = r_ack;
  assign msg_done = r_done;
  assign msg_busy = r_busy;
  assign src      = r_src;
  assign bit_7    = r_disp[31:28];
  assign bit_6    = r_disp[27:24];
  assign bit_5    = r_disp[23:20];
  assign bit_4    = r_disp[19:16];
  assign bit_3    = r_disp[15:12];
  assign bit_2    = r_disp[11:8];
  assign bit_1    = r_disp[7:4];
  assign bit_0    = r_disp[3:0];

endmodule

// File: doc/disp_source_arbiter.md
Name: disp_source_arbiter

Overview:
- Shares the 8-digit seven-segment display between two producers:
  - a continuous data channel, e.g. the live EEPROM address/data readout;
  - a one-shot message channel, e.g. "PASS"/"ERR" style status words.
- Message requests pre-empt data, are held on screen for a guaranteed minimum time, and can optionally blink.
- Sits between the test-control logic and the display scan/decode block; drives that block's eight 4-bit digit codes.
- Digit codes: 0-9 digits, A blank, B dash, C "C", D "H", E "L", F "P".

Parameters:
- CLK_PER_MS, 50000, sclk cycles per millisecond (50 MHz).
- HOLD_MS, 1000, message display time in ms; must be >= 1.
- BLINK_MS, 250, blink half-period in ms; must be >= 1.

Ports:
- sclk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data_valid  in  1  data channel has content (level).
- data_digits  in  32  data codes, [31:28]=leftmost digit 7 ... [3:0]=digit 0.
- msg_req  in  1  message request (level, held until msg_ack).
- msg_digits  in  32  message codes; stable while msg_req is high.
- msg_blink  in  1  blink enable; sampled with msg_digits.
- msg_ack  out  1  1-cycle pulse: message latched.
- msg_done  out  1  1-cycle pulse: hold time expired.
- msg_busy  out  1  high while in SHOW_MSG.
- src  out  2  current source: 0 idle, 1 data, 2 message.
- bit_7..bit_0  out  4 each  digit codes to the display block.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- Reset values:
  - bit_7..bit_0 = 4'hA (blank);
  - src = 0; msg_ack = msg_done = msg_busy = 0;
  - state = IDLE; prescaler, ms counter and blink phase = 0.
- Reset asserted mid-message aborts the message silently: no msg_done is issued.
- States: IDLE, SHOW_DATA, SHOW_MSG.
- IDLE:
  - Outputs all 4'hB (dashes); src = 0.
  - msg_req -> SHOW_MSG. Otherwise data_valid -> SHOW_DATA.
- SHOW_DATA:
  - Each cycle, bit_* <= data_digits, giving 1-cycle latency from the input; src = 1.
  - msg_req has priority -> SHOW_MSG.
  - !data_valid -> IDLE.
- Entry to SHOW_MSG (the cycle msg_req is seen high and the block is not busy):
  - Latch msg_digits and msg_blink into the message register; msg_ack = 1 for this one cycle.
  - Clear the prescaler, ms counter and blink phase.
  - Next cycle: msg_busy = 1, src = 2, outputs show the latched message.
- SHOW_MSG:
  - Prescaler counts 0..CLK_PER_MS-1; a ms tick fires on the terminal count.
  - ms counter increments on each tick.
  - If blink is latched, the blink phase toggles every BLINK_MS ticks. Visible phase (starting phase) shows the message; blank phase shows all 4'hA.
  - msg_req is not acknowledged while busy; the requester keeps it high.
- Hold expiry: on the tick that makes ms counter = HOLD_MS, i.e. exactly HOLD_MS*CLK_PER_MS cycles after the ack cycle:
  - msg_done pulses for 1 cycle.
  - If msg_req is high in the same cycle: re-ack (msg_ack and msg_done both pulse), latch the new message, restart timers, stay in SHOW_MSG. There is no data/idle gap.
  - Else go to SHOW_DATA if data_valid, else IDLE; msg_busy drops the following cycle.
- Data input changes during SHOW_MSG are ignored; the data channel resumes live on return.
- Widths: prescaler $clog2(CLK_PER_MS); ms counter $clog2(HOLD_MS+1). Counters never wrap past their terminal counts.

Decomposition:
- Shared package `disp_pkg`:
  - digit code constants: CODE_BLANK=4'hA, CODE_DASH=4'hB, CODE_C, CODE_H, CODE_L, CODE_P;
  - state enum {IDLE, SHOW_DATA, SHOW_MSG};
  - src encoding constants SRC_IDLE, SRC_DATA, SRC_MSG.
- One sub-module, `ms_tick_gen`:
  - ports sclk, rst, clr, tick;
  - parameter CLK_PER_MS;
  - reusable by other timed display controllers.

Test Plan (bench parameters: CLK_PER_MS=4, HOLD_MS=3, BLINK_MS=1):
1. Reset, then all inputs 0 -> first cycle after reset: bit_* = A, src = 0; next cycle: all B, src = 0.
2. data_valid = 1, data_digits = 32'h0000_1234 -> one cycle later bit_3..0 = 1,2,3,4, src = 1. Change data to 32'h5678_9ABF -> outputs follow with 1-cycle latency.
3. While showing data, msg_req with msg_digits = 32'hFAA5_5AAA ("PASS" style), blink = 0:
   - msg_ack on the first cycle;
   - message shown for 12 cycles;
   - msg_done on cycle 12;
   - data resumes next cycle with src = 1.
4. Message with blink = 1 -> display alternates message / all-A every 4 cycles, starting visible; msg_done after 12 cycles.
5. Second msg_req (32'hE11E_EEEE) held high during an active message -> no ack until expiry. At expiry msg_done and msg_ack pulse in the same cycle, and the new message shows with no gap.
6. Sync rst asserted 5 cycles into a message -> next cycle all outputs at reset values, no msg_done. After release with no inputs: dashes, src = 0.
